// File: rtl/lm32_dtlb_refill.sv
// ----------------------------------------------------------------------------
// lm32_dtlb_refill
//   Hardware refill engine for the LM32 data TLB. On a DTLB miss it reads the
//   page-table entry of the faulting virtual page (single-level table, one
//   32-bit PTE per page) and installs the translation through the DTLB CSR
//   write path: TLB_VADDRESS first, then TLB_PADDRESS.
//
//   Optional feature macro: CFG_DTLB_REFILL_TIMEOUT_EN
//     defined   - FETCH gives up after `timeout` cycles without ack/err
//     undefined - FETCH waits indefinitely; no counter is built
// ----------------------------------------------------------------------------

`ifndef LM32_CSR_RNG
`define LM32_CSR_RNG 4:0
`endif
`ifndef LM32_CSR_TLB_VADDRESS
`define LM32_CSR_TLB_VADDRESS 5'h11
`endif
`ifndef LM32_CSR_TLB_PADDRESS
`define LM32_CSR_TLB_PADDRESS 5'h12
`endif

module lm32_dtlb_refill #(
    parameter int page_size = 4096,
    parameter int timeout   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable,
    input  logic                 miss_req,
    input  logic [31:0]          miss_vaddr,
    input  logic [31:0]          ptbr,
    input  logic                 tlb_busy,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_ack,
    input  logic                 mem_err,
    input  logic [31:0]          mem_rdata,
    output logic [`LM32_CSR_RNG] csr,
    output logic [31:0]          csr_write_data,
    output logic                 csr_write_enable,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic [31:0]          fault_addr
);

    // Page geometry: the low PG_SH address bits are the page offset.
    localparam int PG_SH = $clog2(page_size);
    localparam int VPN_W = 32 - PG_SH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WRV   = 3'd2,
        ST_WRP   = 3'd3,
        ST_RESP  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [31:0]            r_vaddr_q;
    logic [VPN_W-1:0]       r_pfn;

    logic                   r_mem_req;
    logic [31:0]            r_mem_addr;
    logic [`LM32_CSR_RNG]   r_csr;
    logic [31:0]            r_csr_data;
    logic                   r_wr_phase;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_fault;
    logic [31:0]            r_fault_addr;

    logic [VPN_W-1:0]       w_miss_vpn;
    logic [31:0]            w_pte_addr;
    logic                   w_accept;
    logic                   w_tmo_hit;
    logic                   w_unused;

    // PTE address of the incoming miss; the add wraps modulo 2^32.
    assign w_miss_vpn = miss_vaddr[31:PG_SH];
    assign w_pte_addr = {ptbr[31:2], 2'b00} + ({{PG_SH{1'b0}}, w_miss_vpn} << 2'd2);
    assign w_accept   = (r_state == ST_IDLE) && (w_state_nxt == ST_FETCH);

`ifdef CFG_DTLB_REFILL_TIMEOUT_EN
    localparam int TMO_BITS = $clog2(timeout + 1);
    localparam int CNT_W    = (TMO_BITS < 8) ? 8 : ((TMO_BITS > 32) ? 32 : TMO_BITS);

    logic [CNT_W-1:0]       r_tmo_cnt;
    logic [CNT_W-1:0]       w_tmo_inc;

    // The count reaching `timeout` at the end of a FETCH cycle ends the fetch,
    // so mem_req is high for exactly `timeout` cycles.
    assign w_tmo_inc = r_tmo_cnt + CNT_W'(1'b1);
    assign w_tmo_hit = (w_tmo_inc == CNT_W'(timeout));

    // FETCH wait counter: cleared on entry to FETCH, counts idle FETCH cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_FETCH) && !mem_ack && !mem_err) begin
            r_tmo_cnt <= w_tmo_inc;
        end
    end

    assign w_unused = ^{miss_vaddr[PG_SH-1:0], ptbr[1:0], mem_rdata[PG_SH-1:0]};
`else
    assign w_tmo_hit = 1'b0;
    assign w_unused  = ^{miss_vaddr[PG_SH-1:0], ptbr[1:0], mem_rdata[PG_SH-1:0],
                         32'(timeout)};
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: error beats ack, ack beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable && miss_req) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_err) begin
                    w_state_nxt = ST_FAULT;
                end else if (mem_ack) begin
                    if (mem_rdata[0]) begin
                        w_state_nxt = ST_WRV;
                    end else begin
                        w_state_nxt = ST_FAULT;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_WRV: begin
                if (!tlb_busy) begin
                    w_state_nxt = ST_WRP;
                end else begin
                    w_state_nxt = ST_WRV;
                end
            end
            ST_WRP: begin
                if (!tlb_busy) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WRP;
                end
            end
            ST_RESP:  w_state_nxt = ST_IDLE;
            ST_FAULT: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Miss context: faulting address on accept, PFN on a valid PTE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vaddr_q <= 32'h0000_0000;
            r_pfn     <= '0;
        end else begin
            if (w_accept) begin
                r_vaddr_q <= miss_vaddr;
            end
            if ((r_state == ST_FETCH) && (w_state_nxt == ST_WRV)) begin
                r_pfn <= mem_rdata[31:PG_SH];
            end
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem_req    <= 1'b0;
            r_mem_addr   <= 32'h0000_0000;
            r_csr        <= '0;
            r_csr_data   <= 32'h0000_0000;
            r_wr_phase   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_addr <= 32'h0000_0000;
        end else begin
            r_mem_req  <= (w_state_nxt == ST_FETCH);
            r_wr_phase <= (w_state_nxt == ST_WRV) || (w_state_nxt == ST_WRP);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= (w_state_nxt == ST_RESP);
            r_fault    <= (w_state_nxt == ST_FAULT);
            if (w_accept) begin
                r_mem_addr <= w_pte_addr;
            end
            if (w_state_nxt == ST_FAULT) begin
                r_fault_addr <= r_vaddr_q;
            end
            // Op field [5:1] stays zero (NOOP); bit 0 selects the DTLB.
            case (w_state_nxt)
                ST_WRV: begin
                    r_csr      <= `LM32_CSR_TLB_VADDRESS;
                    r_csr_data <= {r_vaddr_q[31:PG_SH], {(PG_SH-1){1'b0}}, 1'b1};
                end
                ST_WRP: begin
                    r_csr      <= `LM32_CSR_TLB_PADDRESS;
                    r_csr_data <= {r_pfn, {(PG_SH-1){1'b0}}, 1'b1};
                end
                default: begin
                    r_csr      <= '0;
                    r_csr_data <= 32'h0000_0000;
                end
            endcase
        end
    end

    // The write strobe must react to tlb_busy in the same cycle, so it is the
    // registered write phase gated by the live busy input.
    assign csr_write_enable = r_wr_phase && !tlb_busy;

    assign mem_req        = r_mem_req;
    assign mem_addr       = r_mem_addr;
    assign csr            = r_csr;
    assign csr_write_data = r_csr_data;
    assign busy           = r_busy;
    assign done           = r_done;
    assign fault          = r_fault;
    assign fault_addr     = r_fault_addr;

endmodule

// File: doc/lm32_dtlb_refill.md
# lm32_dtlb_refill

Hardware refill engine for the LM32 data TLB: on a DTLB miss it fetches the page-table entry for the faulting virtual page from memory and writes the translation into the DTLB through the TLB CSR write path (`LM32_CSR_TLB_VADDRESS`, then `LM32_CSR_TLB_PADDRESS`). It drives the same CSR index, data and write-enable inputs that software uses to update the DTLB. It sits beside `lm32_dtlb` in the MMU-enabled CPU, between the DTLB miss output, a single-beat memory read port and the DTLB CSR update port. The page table is single-level: one 32-bit PTE per virtual page.

## Interface
Parameters:
- page_size, 4096: system page size in bytes; must match the DTLB.
- timeout, 255: FETCH-cycle limit before a bus fault. Used only with `CFG_DTLB_REFILL_TIMEOUT_EN`.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- enable  in  1  refill enable; the DTLB enable bit
- miss_req  in  1  DTLB miss (level, from the DTLB miss output)
- miss_vaddr  in  32  faulting virtual address (DTLB `address_m`)
- ptbr  in  32  page-table base; bits [1:0] ignored
- tlb_busy  in  1  DTLB busy/flushing (its `stall_request`)
- mem_req  out  1  memory read request
- mem_addr  out  32  PTE address, word aligned
- mem_ack  in  1  read data valid; ends the request
- mem_err  in  1  bus error; ends the request
- mem_rdata  in  32  PTE
- csr  out  `LM32_CSR_RNG`  CSR index to the DTLB
- csr_write_data  out  32  CSR write data to the DTLB
- csr_write_enable  out  1  CSR write strobe to the DTLB
- busy  out  1  refill in progress (state != IDLE)
- done  out  1  one-cycle pulse: translation installed
- fault  out  1  one-cycle pulse: invalid PTE, bus error or timeout
- fault_addr  out  32  virtual address of the last fault

## Operation
- PTE format: bit0 = valid; [31:log2(page_size)] = physical frame number (PFN); all other bits ignored.
- vpn = vaddr_q[31:log2(page_size)].
- mem_addr = {ptbr[31:2], 2'b00} + (vpn << 2), computed modulo 2^32 (wraps, no carry out).
- States:
  - IDLE: if enable && miss_req, latch miss_vaddr into vaddr_q and go to FETCH. Otherwise miss_req is ignored, and it is ignored in every non-IDLE state.
  - FETCH: mem_req=1 and mem_addr held stable until mem_ack or mem_err.
    - mem_err (has priority over mem_ack in the same cycle) -> FAULT.
    - mem_ack with rdata[0]=0 -> FAULT.
    - mem_ack with rdata[0]=1 -> latch PFN, go to WRV.
  - WRV: csr=`LM32_CSR_TLB_VADDRESS`, csr_write_data={vpn, zeros, 1'b1}. Op field [5:1]=0 (NOOP); bit0=1 selects the DTLB. csr_write_enable=!tlb_busy. Advance to WRP on the first cycle with !tlb_busy.
  - WRP: csr=`LM32_CSR_TLB_PADDRESS`, csr_write_data={PFN, zeros, 1'b1}. csr_write_enable=!tlb_busy. Advance to RESP on the first cycle with !tlb_busy.
  - RESP: done=1, go to IDLE.
  - FAULT: fault=1, fault_addr<=vaddr_q, go to IDLE. No CSR write is issued.
- Write order is fixed: VADDRESS before PADDRESS. The DTLB commits its entry on the PADDRESS write, using the previously written VADDRESS.
- csr_write_enable is never asserted while tlb_busy=1, or outside WRV/WRP.
- Dropping enable mid-refill does not abort the refill.

## Timing
- Reset values: all outputs 0; csr=0; fault_addr=0; state IDLE.
- rst_i asserted in any state: every output returns to its reset value at the next edge, including mem_req; an in-flight request is abandoned.
- Miss sampled at edge 0. mem_req is high from cycle 1.
- Zero-wait ack (ack in cycle 1): WRV in cycle 2, WRP in cycle 3, done in cycle 4, IDLE in cycle 5.
- Minimum miss-to-done latency is 4 cycles. Each wait cycle on mem_ack or tlb_busy adds one cycle.
- mem_ack and mem_err are only sampled in FETCH.
- After done or fault there is at least one IDLE cycle before the next miss is accepted.

## Configuration
- `CFG_DTLB_REFILL_TIMEOUT_EN` defined:
  - An 8..32-bit counter clears on entry to FETCH and increments on each FETCH cycle without mem_ack/mem_err.
  - When the count equals `timeout`: drop mem_req, go to FAULT.
  - A mem_ack in that same cycle wins.
- Undefined: FETCH waits indefinitely. No counter logic is built and the `timeout` parameter is unused.

## Test plan
- Basic refill: ptbr=0x4000_0000, miss_vaddr=0x0001_2345, ack on the first cycle with rdata=0x8765_4001 -> mem_addr=0x4000_0048; WRV data 0x0001_2001; WRP data 0x8765_4001; done 4 cycles after the miss.
- Invalid PTE: rdata=0x8765_4000 -> fault pulse; fault_addr=0x0001_2345; no csr_write_enable.
- mem_err and mem_ack together in FETCH -> fault, no CSR writes.
- Busy DTLB: tlb_busy high for 3 cycles on entry to WRV -> csr_write_enable stays low 3 cycles, then the VADDRESS write; done 3 cycles later than nominal.
- Wrap and reset: ptbr=0xFFFF_F000, vaddr=0x0040_0000 -> mem_addr=0x0000_0000. Then assert rst_i in FETCH -> mem_req=0 next cycle; a new miss is accepted cleanly.
- Timeout (macro on, timeout=16): no ack -> mem_req high for exactly 16 cycles, then fault. With the macro off: mem_req stays high for 100+ cycles.
